// File: rtl/aes_pkg.sv
// Shared constants and types for the AES receive path.
package aes_pkg;

  localparam int AES_WORD_W          = 32;
  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef enum logic {
    PK_FILL,
    PK_PENDING
  } packer_state_t;

endpackage

// File: rtl/aes_block_packer_sat_counter.sv
// Saturating up-counter with synchronous clear; a same-cycle clear and increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs bus words MSB-word-first into 128-bit blocks for the receive FIFO.
// Optional drop counter enabled by defining AES_PACKER_DROP_CNT_EN.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int  WORD_W          = AES_WORD_W,
  parameter int  WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK,
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK,
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               word_valid,
  input  logic [WORD_W-1:0]  word_data,
  output logic               word_ready,
  input  logic               flush,
  input  logic               fix_error,
  input  logic               fifo_full,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_enq,
  output logic [CNT_W-1:0]   fill_level,
  output logic               framing_error
`ifdef AES_PACKER_DROP_CNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  packer_state_t      state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               err_q, err_d;
  logic               drop;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PK_FILL;
      count_q <= '0;
      block_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      block_q <= block_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    block_d    = block_q;
    err_d      = err_q;
    word_ready = 1'b0;
    block_enq  = 1'b0;
    drop       = 1'b0;

    unique case (state_q)
      PK_FILL: begin
        word_ready = !flush;
        if (flush) begin
          count_d = '0;
          block_d = '0;
        end else if (word_valid) begin
          // Constant slice per slot keeps the insert mux free of variable part-selects.
          for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (count_q == CNT_W'(k)) begin
              block_d[BLOCK_W-1-k*WORD_W -: WORD_W] = word_data;
            end
          end
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            state_d = PK_PENDING;
          end
        end
      end

      PK_PENDING: begin
        block_enq = !fifo_full;
        drop      = word_valid && !flush;
        if (!fifo_full) begin
          state_d = PK_FILL;
          count_d = '0;
        end
      end

      default: state_d = PK_FILL;
    endcase

    if (drop) begin
      err_d = 1'b1;
    end else if (fix_error) begin
      err_d = 1'b0;
    end
  end

  assign block_out     = block_q;
  assign fill_level    = count_q;
  assign framing_error = err_q;

`ifdef AES_PACKER_DROP_CNT_EN
  sat_counter #(
    .W(8)
  ) u_drop_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (drop),
    .clr  (fix_error),
    .count(drop_count)
  );
`endif

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed self-checking bench for aes_block_packer (drop counter checked when AES_PACKER_DROP_CNT_EN is defined).
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_ready;
  logic         flush;
  logic         fix_error;
  logic         fifo_full;
  logic [127:0] block_out;
  logic         block_enq;
  logic [2:0]   fill_level;
  logic         framing_error;
`ifdef AES_PACKER_DROP_CNT_EN
  logic [7:0]   drop_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  w [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [127:0] blk_w = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  aes_block_packer dut (
    .clk          (clk),
    .rst          (rst),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .flush        (flush),
    .fix_error    (fix_error),
    .fifo_full    (fifo_full),
    .block_out    (block_out),
    .block_enq    (block_enq),
    .fill_level   (fill_level),
    .framing_error(framing_error)
`ifdef AES_PACKER_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    word_valid = 1'b1;
    word_data  = d;
    step();
    word_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; word_valid = 1'b0; word_data = '0; flush = 1'b0;
    fix_error = 1'b0; fifo_full = 1'b0;
    #12;
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    checks++; if (block_out !== 128'd0) begin errors++; $display("FAIL reset_block: got %h want 0", block_out); end
    checks++; if ({block_enq, framing_error, word_ready} !== 3'b001) begin errors++; $display("FAIL reset_flags: enq/err/ready got %b want 001", {block_enq, framing_error, word_ready}); end
`ifdef AES_PACKER_DROP_CNT_EN
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1; word_data = w[i];
      #1;
      checks++; if ({word_ready, block_enq} !== 2'b10) begin errors++; $display("FAIL basic_accept%0d: ready/enq got %b want 10", i, {word_ready, block_enq}); end
      step();
      checks++; if (fill_level !== 3'(i + 1)) begin errors++; $display("FAIL basic_fill%0d: got %0d want %0d", i, fill_level, i + 1); end
    end
    word_valid = 1'b0;
    #1;
    checks++; if ({block_enq, word_ready} !== 2'b10) begin errors++; $display("FAIL basic_enq: enq/ready got %b want 10", {block_enq, word_ready}); end
    checks++; if (block_out !== blk_w) begin errors++; $display("FAIL basic_block: got %h want %h", block_out, blk_w); end
    step();
    checks++; if ({block_enq, fill_level} !== 4'b0000) begin errors++; $display("FAIL basic_after: enq=%b fill=%0d want 0,0", block_enq, fill_level); end
  endtask

  task automatic test_stall();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) write_word(w[i]);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin word_valid = 1'b1; word_data = 32'hDEADBEEF; end
      #1;
      checks++; if (block_enq !== 1'b0 || block_out !== blk_w) begin errors++; $display("FAIL stall_hold%0d: enq=%b block=%h want 0,%h", c, block_enq, block_out, blk_w); end
      step();
      word_valid = 1'b0;
    end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL stall_ferr: got %b want 1", framing_error); end
`ifdef AES_PACKER_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL stall_drop: got %0d want 1", drop_count); end
`endif
    fifo_full = 1'b0;
    #1;
    checks++; if (block_enq !== 1'b1 || block_out !== blk_w) begin errors++; $display("FAIL stall_release: enq=%b block=%h want 1,%h", block_enq, block_out, blk_w); end
    step();
    checks++; if ({block_enq, fill_level} !== 4'b0000) begin errors++; $display("FAIL stall_after: enq=%b fill=%0d want 0,0", block_enq, fill_level); end
    fix_error = 1'b1; step(); fix_error = 1'b0;
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL stall_fix: got %b want 0", framing_error); end
  endtask

  task automatic test_flush();
    write_word(32'h11111111);
    write_word(32'h22222222);
    flush = 1'b1;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", word_ready); end
    step();
    flush = 1'b0;
    checks++; if (fill_level !== 3'd0 || block_out !== 128'd0) begin errors++; $display("FAIL flush_clear: fill=%0d block=%h want 0,0", fill_level, block_out); end
    for (int i = 0; i < 4; i++) write_word(32'hA + 32'(i));
    #1;
    checks++; if (block_enq !== 1'b1 || block_out !== 128'h0000000A_0000000B_0000000C_0000000D) begin errors++; $display("FAIL flush_newblock: enq=%b block=%h want 1,0000000a0000000b0000000c0000000d", block_enq, block_out); end
    step();
  endtask

  task automatic test_flush_pending();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) write_word(w[i]);
    flush = 1'b1; word_valid = 1'b1; word_data = 32'h12345678;
    step(); step();
    word_valid = 1'b0;
    checks++; if (fill_level !== 3'd4 || word_ready !== 1'b0) begin errors++; $display("FAIL fpend_hold: fill=%0d ready=%b want 4,0", fill_level, word_ready); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL fpend_noerr: got %b want 0", framing_error); end
    flush = 1'b0; fifo_full = 1'b0;
    #1;
    checks++; if (block_enq !== 1'b1 || block_out !== blk_w) begin errors++; $display("FAIL fpend_enq: enq=%b block=%h want 1,%h", block_enq, block_out, blk_w); end
    step();
    flush = 1'b1; word_valid = 1'b1; word_data = 32'h55555555;
    #1;
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL ffill_ready: got %b want 0", word_ready); end
    step();
    flush = 1'b0; word_valid = 1'b0;
    checks++; if (fill_level !== 3'd0 || framing_error !== 1'b0) begin errors++; $display("FAIL ffill_drop: fill=%0d err=%b want 0,0", fill_level, framing_error); end
  endtask

  task automatic test_error();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) write_word(w[i]);
    write_word(32'hBAD0BAD0);
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", framing_error); end
    fix_error = 1'b1; step(); fix_error = 1'b0;
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", framing_error); end
`ifdef AES_PACKER_DROP_CNT_EN
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL err_drop_clear: got %0d want 0", drop_count); end
`endif
    fix_error = 1'b1; write_word(32'hBAD1BAD1); fix_error = 1'b0;
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", framing_error); end
`ifdef AES_PACKER_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL err_drop_same: got %0d want 1", drop_count); end
`endif
    fifo_full = 1'b0; step();
    fix_error = 1'b1; step(); fix_error = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) write_word(w[i]);
    #2; rst = 1'b1; #1;
    checks++; if (fill_level !== 3'd0 || block_out !== 128'd0 || block_enq !== 1'b0) begin errors++; $display("FAIL rst_partial: fill=%0d block=%h enq=%b want 0,0,0", fill_level, block_out, block_enq); end
    rst = 1'b0;
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) write_word(w[i]);
    checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL rst_pending_fill: got %0d want 4", fill_level); end
    #2; rst = 1'b1; #1;
    checks++; if (fill_level !== 3'd0 || block_out !== 128'd0 || word_ready !== 1'b1) begin errors++; $display("FAIL rst_pending: fill=%0d block=%h ready=%b want 0,0,1", fill_level, block_out, word_ready); end
    rst = 1'b0; fifo_full = 1'b0;
    #1;
    checks++; if (block_enq !== 1'b0) begin errors++; $display("FAIL rst_noenq0: got %b want 0", block_enq); end
    step();
    checks++; if (block_enq !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("FAIL rst_noenq1: enq=%b fill=%0d want 0,0", block_enq, fill_level); end
  endtask

`ifdef AES_PACKER_DROP_CNT_EN
  task automatic test_saturation();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) write_word(w[i]);
    word_valid = 1'b1; word_data = 32'hFFFF0000;
    repeat (300) step();
    word_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
    fifo_full = 1'b0; step();
    fix_error = 1'b1; step(); fix_error = 1'b0;
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", drop_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_flush_pending();
    test_error();
    test_reset_mid();
`ifdef AES_PACKER_DROP_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
